// File: rtl/loteria_emissor_if.sv
// Ticket-offer and bet-stream signals between the ticket source, the emissor and the checker.
interface loteria_emissor_if #(
    parameter int DIGITS    = 5,
    parameter int MAX_JOGOS = 5
);
    localparam int JW = $clog2(MAX_JOGOS + 1);

    logic                load;
    logic [4*DIGITS-1:0] ticket;
    logic                ready;
    logic [3:0]          numero;
    logic                insere;
    logic                fim_jogo;
    logic                fim;
    logic [JW-1:0]       jogos;
    logic                erro;

    modport master (
        output load, ticket,
        input  ready, numero, insere, fim_jogo, fim, jogos, erro
    );
    modport slave (
        input  load, ticket,
        output ready, numero, insere, fim_jogo, fim, jogos, erro
    );
endinterface

// File: rtl/loteria_emissor.sv
// Serialises a parallel ticket onto numero/insere, one digit per strobe, then pulses fim_jogo.
// Optional LOTERIA_DIGIT_CHECK_EN: tickets holding a digit above 9 are refused with an erro strobe.
module loteria_emissor #(
    parameter int DIGITS    = 5,
    parameter int GAP       = 1,
    parameter int MAX_JOGOS = 5
) (
    input  logic              clock,
    input  logic              reset,
    loteria_emissor_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int JW    = $clog2(MAX_JOGOS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_END  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [JW-1:0]       jogos_q, jogos_d;
    logic [4*DIGITS-1:0] ticket_q, ticket_d;
    logic                erro_q, erro_d;
    logic [3:0]          digit_q [DIGITS];
    logic                ticket_ok;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_q[gi] = ticket_q[4*gi +: 4];
        end
    endgenerate

`ifdef LOTERIA_DIGIT_CHECK_EN
    logic [DIGITS-1:0] digit_bad;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
            assign digit_bad[gi] = (bus.ticket[4*gi +: 4] > 4'd9);
        end
    endgenerate
    assign ticket_ok = ~|digit_bad;
`else
    assign ticket_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        jogos_d  = jogos_q;
        ticket_d = ticket_q;
        erro_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    if (ticket_ok) begin
                        ticket_d = bus.ticket;
                        idx_d    = '0;
                        state_d  = S_SEND;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    state_d = S_END;
                end else begin
                    idx_d = idx_q + 1'b1;
                    gap_d = '0;
                    if (GAP > 0) state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_END: begin
                // Saturating count; DONE is entered on the game that reaches the limit.
                if (jogos_q != JW'(MAX_JOGOS)) jogos_d = jogos_q + 1'b1;
                state_d = (jogos_d == JW'(MAX_JOGOS)) ? S_DONE : S_IDLE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            jogos_q  <= '0;
            ticket_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            jogos_q  <= jogos_d;
            ticket_q <= ticket_d;
            erro_q   <= erro_d;
        end
    end

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.insere   = (state_q == S_SEND);
    assign bus.numero   = (state_q == S_SEND) ? digit_q[idx_q] : 4'h0;
    assign bus.fim_jogo = (state_q == S_END);
    assign bus.fim      = (state_q == S_DONE);
    assign bus.jogos    = jogos_q;
    assign bus.erro     = erro_q;
endmodule

// File: tb/tb_loteria_emissor.sv
// Directed bench: two emissors (GAP=1 and GAP=0) checked cycle by cycle against a scoreboard of expected strobes.
module tb_loteria_emissor;
    localparam int D  = 5;
    localparam int MJ = 5;
    localparam int P1 = D + (D - 1) * 1 + 2;   // cycles per game incl. the IDLE accept cycle, GAP=1

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    loteria_emissor_if #(.DIGITS(D), .MAX_JOGOS(MJ)) bus1 ();
    loteria_emissor_if #(.DIGITS(D), .MAX_JOGOS(MJ)) bus0 ();

    loteria_emissor #(.DIGITS(D), .GAP(1), .MAX_JOGOS(MJ)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );
    loteria_emissor #(.DIGITS(D), .GAP(0), .MAX_JOGOS(MJ)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        int         cyc;
        logic [3:0] dig;
    } ins_t;

    ins_t ins1_q[$];
    ins_t ins0_q[$];
    int   fj1_q[$];
    int   fj0_q[$];
    int   erro_cyc = -1;
    int   cyc      = 0;
    int   tests    = 0;
    int   fails    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Expected strobes of one game whose accepting edge follows observation cycle base.
    function automatic void push_game(input int base, input logic [4*D-1:0] t, input int gap, input bit which);
        ins_t e;
        for (int i = 0; i < D; i++) begin
            e.cyc = base + 1 + i * (gap + 1);
            e.dig = t[4*i +: 4];
            if (which) ins1_q.push_back(e);
            else       ins0_q.push_back(e);
        end
        if (which) fj1_q.push_back(base + D + (D - 1) * gap + 1);
        else       fj0_q.push_back(base + D + (D - 1) * gap + 1);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (ins1_q.size() > 0 && ins1_q[0].cyc == cyc) begin
            chk("insere1", 32'(bus1.insere), 32'd1);
            chk("numero1", 32'(bus1.numero), 32'(ins1_q[0].dig));
            void'(ins1_q.pop_front());
        end else begin
            chk("quiet_insere1", 32'(bus1.insere), 32'd0);
            chk("quiet_numero1", 32'(bus1.numero), 32'd0);
        end
        if (fj1_q.size() > 0 && fj1_q[0] == cyc) begin
            chk("fim_jogo1", 32'(bus1.fim_jogo), 32'd1);
            void'(fj1_q.pop_front());
        end else begin
            chk("quiet_fim_jogo1", 32'(bus1.fim_jogo), 32'd0);
        end
        if (ins0_q.size() > 0 && ins0_q[0].cyc == cyc) begin
            chk("insere0", 32'(bus0.insere), 32'd1);
            chk("numero0", 32'(bus0.numero), 32'(ins0_q[0].dig));
            void'(ins0_q.pop_front());
        end else begin
            chk("quiet_insere0", 32'(bus0.insere), 32'd0);
            chk("quiet_numero0", 32'(bus0.numero), 32'd0);
        end
        if (fj0_q.size() > 0 && fj0_q[0] == cyc) begin
            chk("fim_jogo0", 32'(bus0.fim_jogo), 32'd1);
            void'(fj0_q.pop_front());
        end else begin
            chk("quiet_fim_jogo0", 32'(bus0.fim_jogo), 32'd0);
        end
        chk("erro1", 32'(bus1.erro), 32'(cyc == erro_cyc));
        $display("[TB] cycle %0d: ins1=%0b num1=%0h fj1=%0b ins0=%0b num0=%0h fj0=%0b jogos1=%0d",
                 cyc, bus1.insere, bus1.numero, bus1.fim_jogo, bus0.insere, bus0.numero,
                 bus0.fim_jogo, bus1.jogos);
    endtask

    task automatic chk_reset_state();
        chk("rst_ready1",    32'(bus1.ready),    32'd1);
        chk("rst_insere1",   32'(bus1.insere),   32'd0);
        chk("rst_numero1",   32'(bus1.numero),   32'd0);
        chk("rst_fim_jogo1", 32'(bus1.fim_jogo), 32'd0);
        chk("rst_fim1",      32'(bus1.fim),      32'd0);
        chk("rst_jogos1",    32'(bus1.jogos),    32'd0);
        chk("rst_erro1",     32'(bus1.erro),     32'd0);
        chk("rst_ready0",    32'(bus0.ready),    32'd1);
        chk("rst_jogos0",    32'(bus0.jogos),    32'd0);
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk_reset_state();
        ins1_q.delete();
        ins0_q.delete();
        fj1_q.delete();
        fj0_q.delete();
        step();
        #2 reset = 1'b0;
    endtask

    int base;

    initial begin
        bus1.load   = 1'b0;
        bus1.ticket = '0;
        bus0.load   = 1'b0;
        bus0.ticket = '0;

        #2;
        chk_reset_state();
        #11 reset = 1'b0;

        // Idle after reset.
        repeat (5) step();
        chk_reset_state();

        // One game on both instances; a busy-time load on dut1 must be ignored.
        base        = cyc;
        bus1.ticket = 20'h02835;
        bus0.ticket = 20'h02835;
        bus1.load   = 1'b1;
        bus0.load   = 1'b1;
        push_game(base, 20'h02835, 1, 1'b1);
        push_game(base, 20'h02835, 0, 1'b0);
        step();
        bus1.load = 1'b0;
        bus0.load = 1'b0;
        step();
        step();
        bus1.ticket = 20'hFFFFF;
        bus1.load   = 1'b1;
        step();
        bus1.load = 1'b0;
        repeat (5) step();
        chk("game1_ready0",  32'(bus0.ready), 32'd1);
        chk("game1_jogos0",  32'(bus0.jogos), 32'd1);
        step();
        chk("game1_busy_ready1", 32'(bus1.ready), 32'd0);
        step();
        chk("game1_ready1",  32'(bus1.ready), 32'd1);
        chk("game1_jogos1",  32'(bus1.jogos), 32'd1);

        // Reset right after the second digit, then a clean restart from digit 0.
        base        = cyc;
        bus1.ticket = 20'h13579;
        bus1.load   = 1'b1;
        push_game(base, 20'h13579, 1, 1'b1);
        step();
        bus1.load = 1'b0;
        step();
        step();
        do_reset();
        base      = cyc;
        bus1.load = 1'b1;
        push_game(base, 20'h13579, 1, 1'b1);
        step();
        bus1.load = 1'b0;
        repeat (P1 - 1) step();
        chk("restart_jogos1", 32'(bus1.jogos), 32'd1);
        chk("restart_ready1", 32'(bus1.ready), 32'd1);

        // Ticket carrying a non-decimal digit.
        base        = cyc;
        bus1.ticket = 20'h0283A;
        bus1.load   = 1'b1;
`ifdef LOTERIA_DIGIT_CHECK_EN
        erro_cyc = base + 1;
        step();
        bus1.load = 1'b0;
        chk("reject_ready1", 32'(bus1.ready), 32'd1);
        repeat (3) step();
        chk("reject_jogos1", 32'(bus1.jogos), 32'd1);
`else
        push_game(base, 20'h0283A, 1, 1'b1);
        step();
        bus1.load = 1'b0;
        repeat (P1 - 1) step();
        chk("hexdigit_jogos1", 32'(bus1.jogos), 32'd2);
`endif

        // Five games with load held high until fim.
        do_reset();
        base        = cyc;
        bus1.ticket = 20'h02835;
        bus1.load   = 1'b1;
        for (int g = 0; g < MJ; g++) push_game(base + g * P1, 20'h02835, 1, 1'b1);
        repeat (P1) step();
        chk("run_jogos_after1", 32'(bus1.jogos), 32'd1);
        repeat ((MJ - 1) * P1) step();
        chk("done_fim1",   32'(bus1.fim),   32'd1);
        chk("done_ready1", 32'(bus1.ready), 32'd0);
        chk("done_jogos1", 32'(bus1.jogos), 32'(MJ));
        repeat (10) step();
        bus1.load = 1'b0;
        chk("held_fim1",   32'(bus1.fim),   32'd1);
        chk("held_jogos1", 32'(bus1.jogos), 32'(MJ));

        chk("pending_insere1", 32'(ins1_q.size()), 32'd0);
        chk("pending_fj1",     32'(fj1_q.size()),  32'd0);
        chk("pending_insere0", 32'(ins0_q.size()), 32'd0);
        chk("pending_fj0",     32'(fj0_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
